// File: rtl/alu_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_req_arbiter
// Description : Round-robin arbiter and sequencer in front of the shared ALU,
//               returning results on a single tagged response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_req_arbiter #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_mode,
    input  logic             req0_cin,
    input  logic [3:0]       req0_cmd,
    input  logic [1:0]       req0_inp_valid,
    input  logic [WIDTH-1:0] req0_opa,
    input  logic [WIDTH-1:0] req0_opb,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_mode,
    input  logic             req1_cin,
    input  logic [3:0]       req1_cmd,
    input  logic [1:0]       req1_inp_valid,
    input  logic [WIDTH-1:0] req1_opa,
    input  logic [WIDTH-1:0] req1_opb,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH:0]   rsp_res,
    output logic [5:0]       rsp_flags,
    output logic             alu_ce,
    output logic             alu_mode,
    output logic             alu_cin,
    output logic [3:0]       alu_cmd,
    output logic [1:0]       alu_inp_valid,
    output logic [WIDTH-1:0] alu_opa,
    output logic [WIDTH-1:0] alu_opb,
    input  logic [WIDTH:0]   alu_res,
    input  logic             alu_err,
    input  logic             alu_oflow,
    input  logic             alu_cout,
    input  logic             alu_g,
    input  logic             alu_l,
    input  logic             alu_e,
    output logic             busy
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_issue  = 3'd1;
    localparam logic [2:0] c_st_wait   = 3'd2;
    localparam logic [2:0] c_st_bypass = 3'd3;
    localparam logic [2:0] c_st_resp   = 3'd4;
    localparam logic [3:0] c_lat       = 4'(ALU_LAT);

    logic [2:0]       r_state;
    logic             r_last_grant;
    logic             r_id;
    logic [3:0]       r_cnt;
    logic             r_rsp_valid;
    logic [WIDTH:0]   r_rsp_res;
    logic [5:0]       r_rsp_flags;
    logic             r_alu_ce;
    logic             r_alu_mode;
    logic             r_alu_cin;
    logic [3:0]       r_alu_cmd;
    logic [1:0]       r_alu_inp_valid;
    logic [WIDTH-1:0] r_alu_opa;
    logic [WIDTH-1:0] r_alu_opb;

    logic             w_grant;
    logic             w_idle;
    logic             w_hs;
    logic             w_mode;
    logic             w_cin;
    logic [3:0]       w_cmd;
    logic [1:0]       w_inp_valid;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;

    // On a tie the requester that did not win last time gets the grant.
    assign w_grant     = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
    // Reset gates ready so no output can be high while rst is asserted.
    assign w_idle      = (r_state == c_st_idle) && !rst;
    assign req0_ready  = w_idle && req0_valid && !w_grant;
    assign req1_ready  = w_idle && req1_valid && w_grant;
    assign w_hs        = req0_ready || req1_ready;

    assign w_mode      = w_grant ? req1_mode      : req0_mode;
    assign w_cin       = w_grant ? req1_cin       : req0_cin;
    assign w_cmd       = w_grant ? req1_cmd       : req0_cmd;
    assign w_inp_valid = w_grant ? req1_inp_valid : req0_inp_valid;
    assign w_opa       = w_grant ? req1_opa       : req0_opa;
    assign w_opb       = w_grant ? req1_opb       : req0_opb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= c_st_idle;
            r_last_grant    <= 1'b1;
            r_id            <= 1'b0;
            r_cnt           <= 4'd0;
            r_rsp_valid     <= 1'b0;
            r_rsp_res       <= '0;
            r_rsp_flags     <= 6'd0;
            r_alu_ce        <= 1'b0;
            r_alu_mode      <= 1'b0;
            r_alu_cin       <= 1'b0;
            r_alu_cmd       <= 4'd0;
            r_alu_inp_valid <= 2'd0;
            r_alu_opa       <= '0;
            r_alu_opb       <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_hs) begin
                        r_last_grant <= w_grant;
                        r_id         <= w_grant;
                        if (w_inp_valid == 2'b00) begin
                            r_state <= c_st_bypass;
                        end else begin
                            // ALU bus is loaded here so it is live during ISSUE.
                            r_state         <= c_st_issue;
                            r_alu_ce        <= 1'b1;
                            r_alu_mode      <= w_mode;
                            r_alu_cin       <= w_cin;
                            r_alu_cmd       <= w_cmd;
                            r_alu_inp_valid <= w_inp_valid;
                            r_alu_opa       <= w_opa;
                            r_alu_opb       <= w_opb;
                        end
                    end
                end
                c_st_issue: begin
                    r_alu_ce <= 1'b0;
                    r_cnt    <= c_lat;
                    r_state  <= c_st_wait;
                end
                c_st_wait: begin
                    if (r_cnt == 4'd1) begin
                        r_rsp_res   <= alu_res;
                        r_rsp_flags <= {alu_err, alu_oflow, alu_cout, alu_g, alu_l, alu_e};
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_st_resp;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_st_bypass: begin
                    r_rsp_res   <= '0;
                    r_rsp_flags <= 6'b100000;
                    r_rsp_valid <= 1'b1;
                    r_state     <= c_st_resp;
                end
                c_st_resp: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_id;
    assign rsp_res       = r_rsp_res;
    assign rsp_flags     = r_rsp_flags;
    assign alu_ce        = r_alu_ce;
    assign alu_mode      = r_alu_mode;
    assign alu_cin       = r_alu_cin;
    assign alu_cmd       = r_alu_cmd;
    assign alu_inp_valid = r_alu_inp_valid;
    assign alu_opa       = r_alu_opa;
    assign alu_opb       = r_alu_opb;
    assign busy          = (r_state != c_st_idle);

endmodule
`default_nettype wire
